// File: rtl/ahb_cmd_manager.sv
// ahb_cmd_manager: command/data source to AHB-Lite manager issuing SINGLE or INCR bursts.
// Optional hready-stall timeout abort is enabled by defining AHB_CMD_MANAGER_TIMEOUT_EN.
module ahb_cmd_manager #(
    parameter int ADDRWIDTH = 32,
    parameter int DATAWIDTH = 32,
    parameter int MAXLEN    = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic                 hclk,
    input  logic                 hreset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDRWIDTH-1:0] cmd_addr,
    input  logic [4:0]           cmd_len,
    input  logic [3:0]           cmd_wstrb,
    input  logic [DATAWIDTH-1:0] wr_data,
    output logic                 wr_strobe,
    output logic [DATAWIDTH-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 done,
    output logic                 err,
    output logic                 hsel,
    output logic [ADDRWIDTH-1:0] haddr,
    output logic [1:0]           htrans,
    output logic                 hwrite,
    output logic [2:0]           hburst,
    output logic [2:0]           hsize,
    output logic                 hmastlock,
    output logic [3:0]           hwstrb,
    output logic [DATAWIDTH-1:0] hwdata,
    input  logic [DATAWIDTH-1:0] hrdata,
    input  logic                 hready,
    input  logic                 hresp
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA_LAST, ABORT} state_t;
    localparam logic [1:0] TR_IDLE = 2'b00, TR_NONSEQ = 2'b10, TR_SEQ = 2'b11;

    state_t               state_q;
    logic                 cmd_ready_q, hwrite_q, rd_valid_q, done_q, err_q, dph_q;
    logic [1:0]           htrans_q;
    logic [2:0]           hburst_q;
    logic [3:0]           hwstrb_q, wstrb_q;
    logic [4:0]           cnt_q, len_d;
    logic [ADDRWIDTH-1:0] haddr_q, haddr_d;
    logic [DATAWIDTH-1:0] hwdata_q, rd_data_q;
    logic                 live, tmo, abort, adv;

    assign len_d     = (cmd_len == 5'd0) ? 5'd1 : (cmd_len > 5'(MAXLEN)) ? 5'(MAXLEN) : cmd_len;
    assign haddr_d   = haddr_q + ADDRWIDTH'(4);
    assign live      = (state_q == ADDR) || (state_q == DATA_LAST);
    assign abort     = tmo || (hresp && ((state_q == ADDR && dph_q) || state_q == DATA_LAST));
    assign adv       = (state_q == ADDR) && hready && !abort;
    assign wr_strobe = adv && hwrite_q;

    assign cmd_ready = cmd_ready_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign done      = done_q;
    assign err       = err_q;
    assign hsel      = htrans_q[1];
    assign haddr     = haddr_q;
    assign htrans    = htrans_q;
    assign hwrite    = hwrite_q;
    assign hburst    = hburst_q;
    assign hsize     = 3'b010;
    assign hmastlock = 1'b0;
    assign hwstrb    = hwstrb_q;
    assign hwdata    = hwdata_q;

`ifdef AHB_CMD_MANAGER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_q;
    assign tmo = live && !hready && (to_q == TW'(TIMEOUT - 1));
    // count consecutive stalled cycles of an outstanding transfer
    always_ff @(posedge hclk) begin
        if (hreset || !live || hready) to_q <= '0;
        else to_q <= to_q + TW'(1);
    end
`else
    assign tmo = (TIMEOUT < 0);
`endif

    // command sequencing: address phases, pipelined data phases, completion and abort
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            htrans_q    <= TR_IDLE;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hburst_q    <= 3'b000;
            hwstrb_q    <= '0;
            hwdata_q    <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            dph_q       <= 1'b0;
            wstrb_q     <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        state_q     <= ADDR;
                        cmd_ready_q <= 1'b0;
                        htrans_q    <= TR_NONSEQ;
                        haddr_q     <= cmd_addr & ~ADDRWIDTH'(3);
                        hwrite_q    <= cmd_write;
                        hburst_q    <= (len_d == 5'd1) ? 3'b000 : 3'b001;
                        cnt_q       <= len_d;
                        wstrb_q     <= cmd_wstrb;
                        dph_q       <= 1'b0;
                    end
                end
                ADDR: begin
                    if (abort) begin
                        state_q  <= ABORT;
                        htrans_q <= TR_IDLE;
                    end else if (hready) begin
                        if (dph_q && !hwrite_q) begin
                            rd_valid_q <= 1'b1;
                            rd_data_q  <= hrdata;
                        end
                        if (hwrite_q) begin
                            hwdata_q <= wr_data;
                            hwstrb_q <= wstrb_q;
                        end
                        dph_q <= 1'b1;
                        if (cnt_q > 5'd1) begin
                            cnt_q    <= cnt_q - 5'd1;
                            haddr_q  <= haddr_d;
                            htrans_q <= (haddr_d[9:0] == 10'd0) ? TR_NONSEQ : TR_SEQ;
                        end else begin
                            state_q  <= DATA_LAST;
                            htrans_q <= TR_IDLE;
                        end
                    end
                end
                DATA_LAST: begin
                    if (abort) begin
                        state_q <= ABORT;
                    end else if (hready) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        if (!hwrite_q) begin
                            rd_valid_q <= 1'b1;
                            rd_data_q  <= hrdata;
                        end
                    end
                end
                ABORT: begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                    err_q   <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_cmd_manager.sv
// tb_ahb_cmd_manager: randomized bench with AHB memory subordinate and transaction-level reference model.
module tb_ahb_cmd_manager;
    logic        hclk, hreset, cmd_valid, cmd_ready, cmd_write, wr_strobe, rd_valid, done, err;
    logic        hsel, hwrite, hmastlock, hready, hresp;
    logic [31:0] cmd_addr, wr_data, rd_data, haddr, hwdata, hrdata;
    logic [4:0]  cmd_len;
    logic [3:0]  cmd_wstrb, hwstrb;
    logic [1:0]  htrans;
    logic [2:0]  hburst, hsize;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] mem [bit [29:0]];
    logic [31:0] refm [bit [29:0]];

`ifdef AHB_CMD_MANAGER_TIMEOUT_EN
    localparam int HANG = 1000;
`else
    localparam int HANG = 100;
`endif

    ahb_cmd_manager dut (
        .hclk(hclk), .hreset(hreset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wstrb(cmd_wstrb),
        .wr_data(wr_data), .wr_strobe(wr_strobe), .rd_data(rd_data), .rd_valid(rd_valid),
        .done(done), .err(err), .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
        .hburst(hburst), .hsize(hsize), .hmastlock(hmastlock), .hwstrb(hwstrb), .hwdata(hwdata),
        .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_w(bit [29:0] k);
        return ({2'b0, k} * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] rd_mem(bit [29:0] k);
        return mem.exists(k) ? mem[k] : init_w(k);
    endfunction

    function automatic logic [31:0] rd_ref(bit [29:0] k);
        return refm.exists(k) ? refm[k] : init_w(k);
    endfunction

    function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] d, logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~m) | (d & m);
    endfunction

    // eb: beat whose data phase errors (-1 none); mode: 0 ready, 1 random stalls, 2 3-cycle stall on beat 1, 3 hang on beat 1
    task automatic run_cmd(input bit w, input logic [31:0] a, input int len, input logic [3:0] s, input int eb, input int mode);
        int n, nx, ai, pi, stall, lim;
        bit pend, done_seen, abort_chk, hr, er;
        logic [31:0] pa;
        logic [31:0] ea[$];
        logic [1:0]  et[$];
        logic [31:0] wd[$];
        logic [31:0] exp_rd[$];
        n = (len == 0) ? 1 : len;
        nx = (eb >= 0) ? eb + 1 : n;
        for (int i = 0; i < n; i++) begin
            logic [31:0] x;
            x = (a & ~32'h3) + 32'(4 * i);
            ea.push_back(x);
            et.push_back((i == 0 || x[9:0] == 10'd0) ? 2'b10 : 2'b11);
            wd.push_back($urandom);
            if (i < ((eb >= 0) ? eb : n)) begin
                if (w) refm[x[31:2]] = merge(rd_ref(x[31:2]), wd[i], s);
                else exp_rd.push_back(rd_ref(x[31:2]));
            end
        end
        @(negedge hclk);
        check("cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = 5'(len);
        cmd_wstrb = s;
        wr_data   = wd[0];
        @(negedge hclk);
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        check("latency", 32'(htrans), 32'h2);
        ai = 0; pi = 0; pa = 0; pend = 0; stall = 0; abort_chk = 0; done_seen = 0;
        for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
            if (rd_valid) begin
                if (exp_rd.size() == 0) check("rd_extra", 32'(rd_valid), 32'd0);
                else check("rd_data", rd_data, exp_rd.pop_front());
            end
            if (abort_chk) check("abort_idle", 32'(htrans), 32'd0);
            abort_chk = 0;
            if (done) begin
                done_seen = 1;
                check("err", 32'(err), 32'(eb >= 0));
                check("beats", 32'(ai), 32'(nx));
                check("rd_left", 32'(exp_rd.size()), 32'd0);
                check("ready_at_done", 32'(cmd_ready), 32'd0);
                check("idle_at_done", 32'(htrans), 32'd0);
            end else begin
                if (htrans[1]) begin
                    if (ai < n) begin
                        check("haddr", haddr, ea[ai]);
                        check("htrans", 32'(htrans), 32'(et[ai]));
                        check("hburst", 32'(hburst), (n == 1) ? 32'd0 : 32'd1);
                        check("hwrite", 32'(hwrite), 32'(w));
                        check("hsel", 32'(hsel), 32'd1);
                    end else check("extra_addr", 32'(htrans), 32'd0);
                end else check("hsel_idle", 32'(hsel), 32'd0);
                if (pend && w) begin
                    check("hwdata", hwdata, wd[pi]);
                    check("hwstrb", 32'(hwstrb), 32'(s));
                end
                er = pend && pi == eb && mode != 3;
                hr = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
                if ((mode == 2 || mode == 3) && pend && pi == 1) begin
                    lim = (mode == 2) ? 3 : HANG;
                    if (stall < lim) begin
                        hr = 0;
                        stall++;
                    end else if (mode == 3 && stall == lim) begin
                        check("hang_busy", 32'(cmd_ready), 32'd0);
                        stall++;
                    end
                end
                if (er) hr = 0;
                hready  = hr;
                hresp   = er;
                hrdata  = pend ? rd_mem(pa[31:2]) : $urandom;
                wr_data = (ai < n) ? wd[ai] : $urandom;
                #1;
                check("wr_strobe", 32'(wr_strobe), 32'(htrans[1] && hr && w));
                if (er) begin
                    pend = 0;
                    abort_chk = 1;
                end else if (hr) begin
                    if (pend && w) mem[pa[31:2]] = merge(rd_mem(pa[31:2]), hwdata, hwstrb);
                    pend = htrans[1];
                    pa = haddr;
                    pi = ai;
                    if (htrans[1]) ai++;
                end
            end
            @(negedge hclk);
        end
        if (!done_seen) check("done_timeout", 32'(done_seen), 32'd1);
        hready = 1'b1;
        hresp  = 1'b0;
    endtask

    initial begin
        int n, eb;
        logic [31:0] a;
        hreset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        cmd_wstrb = '0; wr_data = '0; hrdata = '0; hready = 1'b1; hresp = 1'b0;
        repeat (2) @(negedge hclk);
        hreset = 1'b0;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_htrans", 32'(htrans), 32'd0);
        check("rst_hsel", 32'(hsel), 32'd0);
        check("rst_haddr", haddr, 32'd0);
        check("rst_hwrite", 32'(hwrite), 32'd0);
        check("rst_hburst", 32'(hburst), 32'd0);
        check("rst_hwstrb", 32'(hwstrb), 32'd0);
        check("rst_hwdata", hwdata, 32'd0);
        check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("hsize", 32'(hsize), 32'd2);
        check("hmastlock", 32'(hmastlock), 32'd0);

        run_cmd(1'b1, 32'h100, 1, 4'hF, -1, 0);
        for (int i = 0; i < 4; i++) begin
            mem[30'(32'h80 + i)]  = 32'(i + 1);
            refm[30'(32'h80 + i)] = 32'(i + 1);
        end
        run_cmd(1'b0, 32'h200, 4, 4'hF, -1, 0);
        run_cmd(1'b1, 32'h300, 4, 4'hF, -1, 2);
        run_cmd(1'b1, 32'h3F8, 4, 4'hF, -1, 0);
        run_cmd(1'b0, 32'h500, 4, 4'hF, 1, 0);
        run_cmd(1'b0, 32'h600, 2, 4'hF, -1, 0);
        run_cmd(1'b1, 32'hFFFFFFF8, 4, 4'h5, -1, 1);
        run_cmd(1'b1, 32'h701, 0, 4'h3, -1, 0);
        run_cmd(1'b0, 32'h800, 16, 4'hF, -1, 1);
        run_cmd(1'b1, 32'h900, 3, 4'hF, 2, 0);
`ifdef AHB_CMD_MANAGER_TIMEOUT_EN
        run_cmd(1'b0, 32'hA00, 4, 4'hF, 1, 3);
`else
        run_cmd(1'b0, 32'hA00, 4, 4'hF, -1, 3);
`endif
        for (int t = 0; t < 40; t++) begin
            a = ($urandom_range(0, 3) == 0) ? (32'hFFFFFF00 | 32'($urandom_range(0, 255))) : 32'($urandom_range(0, 32'h1FFF));
            n = $urandom_range(0, 16);
            eb = ($urandom_range(0, 4) == 0) ? $urandom_range(0, (n == 0) ? 0 : n - 1) : -1;
            run_cmd(1'($urandom_range(0, 1)), a, n, 4'($urandom_range(0, 15)), eb, 1);
        end

        @(negedge hclk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40; cmd_len = 5'd8;
        @(negedge hclk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge hclk);
        check("mid_busy", 32'(htrans[1]), 32'd1);
        hreset = 1'b1;
        @(negedge hclk);
        hreset = 1'b0;
        check("midrst_htrans", 32'(htrans), 32'd0);
        check("midrst_ready", 32'(cmd_ready), 32'd1);
        check("midrst_haddr", haddr, 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        @(negedge hclk);
        check("midrst_no_done", 32'(done), 32'd0);
        check("midrst_idle", 32'(htrans), 32'd0);
        run_cmd(1'b0, 32'h40, 2, 4'hF, -1, 0);

        foreach (refm[k]) check("mem", rd_mem(k), refm[k]);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
